// File: rtl/forex_pkg.sv
// Shared types and constants for the arbitrage Container update path:
// edge-update record, sequencer states and host register map.
package forex_pkg;

  localparam int DEF_NODE_W   = 3;
  localparam int DEF_WEIGHT_W = 32;

  typedef struct packed {
    logic [DEF_NODE_W-1:0]   src;
    logic [DEF_NODE_W-1:0]   dst;
    logic [DEF_WEIGHT_W-1:0] weight;
  } update_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    START = 2'd2,
    WAIT  = 2'd3
  } seq_state_t;

  localparam logic [2:0] ADDR_EDGE   = 3'd0;
  localparam logic [2:0] ADDR_WEIGHT = 3'd1;
  localparam logic [2:0] ADDR_CTRL   = 3'd2;

endpackage

// File: rtl/update_fifo.sv
// Synchronous FIFO of edge updates; a push into a full FIFO is accepted
// only when a pop happens in the same cycle.
module update_fifo
  import forex_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  update_t       din,
  input  logic          pop,
  output update_t       dout,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);

  update_t         mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            push_ok;
  logic            pop_ok;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign dout    = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/update_sequencer.sv
// Host-facing sequencer: buffers edge updates, applies them to the Container
// one per handshake, then launches one run and waits for run_done.
// Optional watchdog on the run wait: define UPDATE_SEQUENCER_WATCHDOG_EN.
module update_sequencer
  import forex_pkg::*;
#(
  parameter int NODE_W    = DEF_NODE_W,
  parameter int WEIGHT_W  = DEF_WEIGHT_W,
  parameter int DEPTH     = 4,
  parameter int WD_CYCLES = 65536
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                chipselect,
  input  logic                write,
  input  logic                read,
  input  logic [2:0]          address,
  input  logic [WEIGHT_W-1:0] writedata,
  output logic [31:0]         readdata,
  output logic                upd_valid,
  input  logic                upd_ready,
  output logic [NODE_W-1:0]   upd_src,
  output logic [NODE_W-1:0]   upd_dst,
  output logic [WEIGHT_W-1:0] upd_weight,
  output logic                run_start,
  input  logic                run_done,
  output logic                busy,
  output logic                irq
);

  localparam int AW = $clog2(DEPTH);

  seq_state_t      state_q, state_d;
  logic [NODE_W-1:0] stage_src, stage_dst;
  logic            push, pop, full, empty, clr;
  logic            run_fin, wd_expire, overflow_evt;
  logic [AW:0]     count;
  update_t         head, fifo_din;
  logic            overflow, timeout;
  logic [15:0]     run_count;
  logic            wd_hit;

  assign push         = chipselect && write && (address == ADDR_WEIGHT);
  assign clr          = chipselect && write && (address == ADDR_CTRL) && writedata[0];
  assign pop          = upd_valid && upd_ready;
  assign overflow_evt = push && full && !pop;
  assign fifo_din     = '{src: stage_src, dst: stage_dst, weight: writedata};

  update_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .din   (fifo_din),
    .pop   (pop),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

`ifdef UPDATE_SEQUENCER_WATCHDOG_EN
  logic [31:0] wd_cnt;

  // Counter is held at zero outside WAIT, so every WAIT entry starts fresh.
  always_ff @(posedge clk) begin
    if (reset || state_q != WAIT) wd_cnt <= '0;
    else                          wd_cnt <= wd_cnt + 1'b1;
  end
  assign wd_hit = (wd_cnt == 32'(WD_CYCLES - 1));
`else
  logic unused_wd;
  assign unused_wd = (WD_CYCLES == 0);
  assign wd_hit    = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    upd_valid = 1'b0;
    run_start = 1'b0;
    run_fin   = 1'b0;
    wd_expire = 1'b0;
    case (state_q)
      IDLE: if (!empty) state_d = LOAD;
      LOAD: begin
        upd_valid = !empty;
        // Last entry leaves and nothing new joins the batch this cycle.
        if (pop && count == (AW+1)'(1) && !push) state_d = START;
      end
      START: begin
        run_start = 1'b1;
        state_d   = WAIT;
      end
      WAIT: begin
        if (run_done) begin
          run_fin = 1'b1;
          state_d = IDLE;
        end else if (wd_hit) begin
          wd_expire = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy       = (state_q != IDLE);
  assign upd_src    = upd_valid ? head.src    : '0;
  assign upd_dst    = upd_valid ? head.dst    : '0;
  assign upd_weight = upd_valid ? head.weight : '0;

  // Set events win over a same-cycle host clear so no event is lost.
  always_ff @(posedge clk) begin
    if (reset) begin
      stage_src <= '0;
      stage_dst <= '0;
      overflow  <= 1'b0;
      timeout   <= 1'b0;
      irq       <= 1'b0;
      run_count <= '0;
    end else begin
      if (chipselect && write && address == ADDR_EDGE) begin
        stage_src <= writedata[2*NODE_W-1:NODE_W];
        stage_dst <= writedata[NODE_W-1:0];
      end
      overflow <= (overflow && !clr) || overflow_evt;
      timeout  <= (timeout && !clr) || wd_expire;
      irq      <= (irq && !clr) || overflow_evt || run_fin || wd_expire;
      if (run_fin) run_count <= run_count + 1'b1;
    end
  end

  always_comb begin
    readdata = '0;
    if (chipselect && read && address == ADDR_CTRL)
      readdata = {run_count, 4'h0, 4'(count), 4'h0, timeout, overflow, busy, irq};
  end

endmodule

// File: tb/tb_update_sequencer.sv
// Directed bench for update_sequencer: a cycle table for the single-update
// flow plus hand-written multi-cycle sequences with an update scoreboard.
module tb_update_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        chipselect = 1'b0, write = 1'b0, read = 1'b0;
  logic [2:0]  address = '0;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic        upd_valid, upd_ready = 1'b0;
  logic [2:0]  upd_src, upd_dst;
  logic [31:0] upd_weight;
  logic        run_start, run_done = 1'b0;
  logic        busy, irq;

  int errors = 0;
  int checks = 0;
  int start_cnt = 0;
  int cyc = 0;
  int s0;
  logic mon_en = 1'b0;
  logic [37:0] exp_q[$];
  int beat_cyc[$];

  update_sequencer #(.NODE_W(3), .WEIGHT_W(32), .DEPTH(4), .WD_CYCLES(16)) dut (
    .clk(clk), .reset(reset), .chipselect(chipselect), .write(write),
    .read(read), .address(address), .writedata(writedata), .readdata(readdata),
    .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_src(upd_src),
    .upd_dst(upd_dst), .upd_weight(upd_weight), .run_start(run_start),
    .run_done(run_done), .busy(busy), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // One cycle: sample mid-low-phase, then advance to the next negedge.
  task automatic step();
    #1;
    if (mon_en && upd_valid && upd_ready) begin
      if (exp_q.size() == 0) chk("unexpected_beat", {upd_src, upd_dst, upd_weight}, 64'hDEAD);
      else chk("upd_beat", {upd_src, upd_dst, upd_weight}, exp_q.pop_front());
      beat_cyc.push_back(cyc);
    end
    if (mon_en && run_start) start_cnt++;
    @(negedge clk);
    cyc++;
    chipselect = 1'b0; write = 1'b0; read = 1'b0; run_done = 1'b0;
  endtask

  task automatic reg_write(input logic [2:0] a, input logic [31:0] d);
    chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
    step();
  endtask

  task automatic read_chk(input string name, input logic [31:0] exp);
    chipselect = 1'b1; read = 1'b1; address = 3'd2;
    #1;
    chk(name, readdata, exp);
    step();
  endtask

  task automatic wait_start(input int base, input int budget);
    int n = 0;
    while (start_cnt == base && n < budget) begin
      step();
      n++;
    end
    chk("run_start_count", start_cnt - base, 1);
  endtask

  task automatic finish_run();
    run_done = 1'b1;
    step();
    reg_write(3'd2, 32'd1);
  endtask

  typedef struct {
    logic        wr, rd;
    logic [2:0]  addr;
    logic [31:0] data;
    logic        rdy, done;
    int          reps;
    logic        e_valid;
    logic [2:0]  e_src, e_dst;
    logic [31:0] e_weight;
    logic        e_start, e_busy, e_irq;
    logic [31:0] e_rdata;
  } vec_t;

  vec_t vecs[13];

  initial begin
    //            wr rd addr data     rdy dn rp val src dst weight   st bsy irq rdata
    vecs[0]  = '{1, 0, 3'd0, 32'h0A,  1, 0, 1, 0, 0, 0, 32'h0,   0, 0, 0, 32'h0};
    vecs[1]  = '{1, 0, 3'd1, 32'h100, 1, 0, 1, 0, 0, 0, 32'h0,   0, 0, 0, 32'h0};
    vecs[2]  = '{0, 1, 3'd2, 32'h0,   1, 0, 1, 0, 0, 0, 32'h0,   0, 0, 0, 32'h0000_0100};
    vecs[3]  = '{0, 0, 3'd0, 32'h0,   1, 0, 1, 1, 1, 2, 32'h100, 0, 1, 0, 32'h0};
    vecs[4]  = '{0, 0, 3'd0, 32'h0,   1, 0, 1, 0, 0, 0, 32'h0,   1, 1, 0, 32'h0};
    vecs[5]  = '{0, 0, 3'd0, 32'h0,   1, 0, 9, 0, 0, 0, 32'h0,   0, 1, 0, 32'h0};
    vecs[6]  = '{0, 0, 3'd0, 32'h0,   1, 1, 1, 0, 0, 0, 32'h0,   0, 1, 0, 32'h0};
    vecs[7]  = '{0, 1, 3'd2, 32'h0,   1, 0, 1, 0, 0, 0, 32'h0,   0, 0, 1, 32'h0001_0001};
    vecs[8]  = '{1, 0, 3'd2, 32'h1,   1, 0, 1, 0, 0, 0, 32'h0,   0, 0, 1, 32'h0};
    vecs[9]  = '{0, 1, 3'd2, 32'h0,   1, 0, 1, 0, 0, 0, 32'h0,   0, 0, 0, 32'h0001_0000};
    vecs[10] = '{1, 0, 3'd3, 32'hFF,  1, 0, 1, 0, 0, 0, 32'h0,   0, 0, 0, 32'h0};
    vecs[11] = '{0, 1, 3'd5, 32'h0,   1, 0, 1, 0, 0, 0, 32'h0,   0, 0, 0, 32'h0};
    vecs[12] = '{0, 1, 3'd2, 32'h0,   1, 0, 1, 0, 0, 0, 32'h0,   0, 0, 0, 32'h0001_0000};

    // Reset state, read strobe asserted to exercise readdata.
    @(negedge clk);
    chipselect = 1'b1; read = 1'b1; address = 3'd2;
    #1;
    chk("rst_readdata", readdata, 32'h0);
    chk("rst_outputs", {upd_valid, upd_src, upd_dst, upd_weight, run_start, busy, irq}, 64'h0);
    reset = 1'b0; chipselect = 1'b0; read = 1'b0;
    @(negedge clk);

    // Single update: table-driven, cycle by cycle.
    for (int i = 0; i < 13; i++) begin
      for (int r = 0; r < vecs[i].reps; r++) begin
        chipselect = vecs[i].wr | vecs[i].rd;
        write = vecs[i].wr; read = vecs[i].rd;
        address = vecs[i].addr; writedata = vecs[i].data;
        upd_ready = vecs[i].rdy; run_done = vecs[i].done;
        #1;
        chk($sformatf("vec%0d_valid", i), upd_valid, vecs[i].e_valid);
        chk($sformatf("vec%0d_upd", i), {upd_src, upd_dst, upd_weight},
            {vecs[i].e_src, vecs[i].e_dst, vecs[i].e_weight});
        chk($sformatf("vec%0d_start", i), run_start, vecs[i].e_start);
        chk($sformatf("vec%0d_busy", i), busy, vecs[i].e_busy);
        chk($sformatf("vec%0d_irq", i), irq, vecs[i].e_irq);
        chk($sformatf("vec%0d_rdata", i), readdata, vecs[i].e_rdata);
        @(negedge clk);
        cyc++;
      end
    end
    chipselect = 1'b0; write = 1'b0; read = 1'b0; run_done = 1'b0;
    mon_en = 1'b1;

    // Three back-to-back updates form one batch of consecutive beats.
    s0 = start_cnt;
    beat_cyc.delete();
    reg_write(3'd0, 32'h1D);
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back({3'd3, 3'd5, 32'h11 * (i + 1)});
      reg_write(3'd1, 32'h11 * (i + 1));
    end
    wait_start(s0, 10);
    repeat (3) step();
    chk("batch3_starts", start_cnt - s0, 1);
    chk("batch3_beats", beat_cyc.size(), 3);
    if (beat_cyc.size() == 3) chk("batch3_consecutive", beat_cyc[2] - beat_cyc[0], 2);
    chk("batch3_q_empty", exp_q.size(), 0);
    finish_run();

    // Overflow while held in WAIT, then the queued batch drains.
    s0 = start_cnt;
    reg_write(3'd0, 32'h14);
    exp_q.push_back({3'd2, 3'd4, 32'hA0});
    reg_write(3'd1, 32'hA0);
    wait_start(s0, 10);
    for (int i = 0; i < 5; i++) begin
      if (i < 4) exp_q.push_back({3'd2, 3'd4, 32'hB0 + i});
      reg_write(3'd1, 32'hB0 + i);
    end
    read_chk("ovf_status", 32'h0002_0407);
    reg_write(3'd2, 32'd1);
    read_chk("ovf_cleared", 32'h0002_0402);
    s0 = start_cnt;
    run_done = 1'b1;
    step();
    wait_start(s0, 20);
    chk("ovf_q_empty", exp_q.size(), 0);
    run_done = 1'b1;
    step();
    read_chk("ovf_done_status", 32'h0004_0001);
    reg_write(3'd2, 32'd1);

    // Stall in LOAD: offer held steady without a handshake.
    s0 = start_cnt;
    upd_ready = 1'b0;
    reg_write(3'd0, 32'h37);
    exp_q.push_back({3'd6, 3'd7, 32'hC0});
    reg_write(3'd1, 32'hC0);
    step();
    for (int i = 0; i < 5; i++) begin
      #1;
      chk($sformatf("stall%0d_offer", i), {upd_valid, upd_src, upd_dst, upd_weight},
          {1'b1, 3'd6, 3'd7, 32'hC0});
      chk($sformatf("stall%0d_start", i), run_start, 0);
      step();
    end
    chk("stall_no_pop", exp_q.size(), 1);
    upd_ready = 1'b1;
    wait_start(s0, 10);
    chk("stall_q_empty", exp_q.size(), 0);
    finish_run();

    // Reset in WAIT with two entries queued.
    s0 = start_cnt;
    reg_write(3'd0, 32'h09);
    exp_q.push_back({3'd1, 3'd1, 32'hD0});
    reg_write(3'd1, 32'hD0);
    wait_start(s0, 10);
    reg_write(3'd1, 32'hD1);
    reg_write(3'd1, 32'hD2);
    read_chk("prereset_status", 32'h0005_0202);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("postreset_busy", busy, 0);
    read_chk("postreset_status", 32'h0);
    s0 = start_cnt;
    run_done = 1'b1;
    step();
    repeat (3) step();
    chk("late_done_no_start", start_cnt - s0, 0);
    read_chk("late_done_status", 32'h0);

    // Watchdog (or indefinite wait without it).
    s0 = start_cnt;
    reg_write(3'd0, 32'h0A);
    exp_q.push_back({3'd1, 3'd2, 32'hE0});
    reg_write(3'd1, 32'hE0);
    wait_start(s0, 10);
`ifdef UPDATE_SEQUENCER_WATCHDOG_EN
    repeat (15) step();
    chk("wd_busy_before", busy, 1);
    step();
    chk("wd_busy_after", busy, 0);
    read_chk("wd_status", 32'h0000_0009);
    run_done = 1'b1;
    step();
    read_chk("wd_late_done", 32'h0000_0009);
`else
    repeat (20) step();
    chk("nowd_busy", busy, 1);
    read_chk("nowd_status", 32'h0000_0002);
    finish_run();
    read_chk("nowd_done_status", 32'h0001_0000);
`endif
    chk("final_q_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
